// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm layer sequencer: FSM encoding and
// the layout of one per-channel parameter record.
package bn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WB     = 3'd4,
        ST_FIN    = 3'd5
    } bn_state_t;

    localparam int OFF_GAMMA    = 0;
    localparam int OFF_BETA     = 1;
    localparam int OFF_MEAN     = 2;
    localparam int OFF_VAR      = 3;
    localparam int RECORD_WORDS = 4;

    // Width of the fetch sub-count (0..RECORD_WORDS).
    localparam int FETCH_K_W    = 3;

endpackage

// File: rtl/bn_param_fetch.sv
// Reads one 4-word channel record from parameter memory (1-cycle read latency)
// and publishes all four words together on the last fetch cycle.
module bn_param_fetch
    import bn_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  logic              active,
    input  logic              kill,
    input  logic [ADDR_W-1:0] rec_base,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              last,
    output logic [DATA_W-1:0] ch_gamma,
    output logic [DATA_W-1:0] ch_beta,
    output logic [DATA_W-1:0] ch_mean,
    output logic [DATA_W-1:0] ch_var
);

    localparam logic [FETCH_K_W-1:0] K_LAST    = FETCH_K_W'(RECORD_WORDS);
    localparam logic [FETCH_K_W-1:0] K_LAST_RD = FETCH_K_W'(RECORD_WORDS - 2);

    logic [FETCH_K_W-1:0] k_q;
    logic [ADDR_W-1:0]    base_q;
    logic [DATA_W-1:0]    gamma_s, beta_s, mean_s;
    logic                 more_reads;

    assign last       = active && (k_q == K_LAST);
    assign more_reads = active && (k_q <= K_LAST_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            base_q   <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            gamma_s  <= '0;
            beta_s   <= '0;
            mean_s   <= '0;
            ch_gamma <= '0;
            ch_beta  <= '0;
            ch_mean  <= '0;
            ch_var   <= '0;
        end else begin
            if (enter) begin
                k_q    <= '0;
                base_q <= rec_base;
            end else if (active) begin
                k_q <= k_q + 1'b1;
            end

            rd_en <= !kill && (enter || more_reads);
            if (enter)
                rd_addr <= rec_base + ADDR_W'(OFF_GAMMA);
            else if (more_reads)
                rd_addr <= base_q + ADDR_W'(k_q) + ADDR_W'(1);

            // Words land one cycle after their read; the datapath-facing
            // copies change only once the whole record is in hand.
            if (active && !kill) begin
                case (k_q)
                    FETCH_K_W'(OFF_GAMMA + 1): gamma_s <= rd_data;
                    FETCH_K_W'(OFF_BETA + 1):  beta_s  <= rd_data;
                    FETCH_K_W'(OFF_MEAN + 1):  mean_s  <= rd_data;
                    K_LAST: begin
                        ch_gamma <= gamma_s;
                        ch_beta  <= beta_s;
                        ch_mean  <= mean_s;
                        ch_var   <= rd_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/bn_layer_sequencer.sv
// Steps a batch-norm layer channel by channel: fetch parameters, launch the
// datapath, wait for it, optionally write back running statistics.
module bn_layer_sequencer
    import bn_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_channels,
    input  logic [15:0]       cmd_feature_size,
    input  logic              cmd_training,
    input  logic [ADDR_W-1:0] cmd_param_base,
    output logic              param_rd_en,
    output logic [ADDR_W-1:0] param_rd_addr,
    input  logic [DATA_W-1:0] param_rd_data,
    output logic              param_wr_en,
    output logic [ADDR_W-1:0] param_wr_addr,
    output logic [DATA_W-1:0] param_wr_data,
    output logic [DATA_W-1:0] ch_gamma,
    output logic [DATA_W-1:0] ch_beta,
    output logic [DATA_W-1:0] ch_mean,
    output logic [DATA_W-1:0] ch_var,
    output logic [15:0]       ch_index,
    output logic              dp_start,
    output logic              dp_training,
    output logic [15:0]       dp_feature_size,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_new_mean,
    input  logic [DATA_W-1:0] dp_new_var,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error
);

    bn_state_t         state_q, state_d;
    logic [15:0]       chan_q, chan_d, chan_inc, num_ch_q;
    logic [ADDR_W-1:0] rec_q, rec_d;
    logic              wb_sel_q, wb_sel_d;
    logic [DATA_W-1:0] mean_q, mean_d, var_q, var_d;
    logic              fetch_enter, fetch_last, fetch_active;
    logic              abort_hit, advance, err_d;

    assign chan_inc     = chan_q + 16'd1;
    assign fetch_active = (state_q == ST_FETCH);
    assign abort_hit    = abort && (state_q != ST_IDLE) && (state_q != ST_FIN);

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        rec_d       = rec_q;
        wb_sel_d    = wb_sel_q;
        mean_d      = mean_q;
        var_d       = var_q;
        err_d       = 1'b0;
        fetch_enter = 1'b0;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_channels == 16'd0) || (cmd_feature_size == 16'd0)) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_FETCH;
                        chan_d      = 16'd0;
                        rec_d       = cmd_param_base;
                        fetch_enter = 1'b1;
                    end
                end
            end
            ST_FETCH:  if (fetch_last) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dp_done) begin
                    if (dp_training) begin
                        state_d  = ST_WB;
                        wb_sel_d = 1'b0;
                        mean_d   = dp_new_mean;
                        var_d    = dp_new_var;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_WB: begin
                if (!wb_sel_q) wb_sel_d = 1'b1;
                else           advance  = 1'b1;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Record addresses advance by a fixed stride and wrap with the address width.
        if (advance) begin
            if (chan_inc == num_ch_q) begin
                state_d = ST_FIN;
            end else begin
                state_d     = ST_FETCH;
                chan_d      = chan_inc;
                rec_d       = rec_q + ADDR_W'(RECORD_WORDS);
                fetch_enter = 1'b1;
            end
        end

        if (abort_hit) begin
            state_d     = ST_FIN;
            err_d       = 1'b1;
            fetch_enter = 1'b0;
            chan_d      = chan_q;
            rec_d       = rec_q;
            wb_sel_d    = wb_sel_q;
            mean_d      = mean_q;
            var_d       = var_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            chan_q          <= '0;
            num_ch_q        <= '0;
            rec_q           <= '0;
            wb_sel_q        <= 1'b0;
            mean_q          <= '0;
            var_q           <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            dp_start        <= 1'b0;
            dp_training     <= 1'b0;
            dp_feature_size <= '0;
            ch_index        <= '0;
            param_wr_en     <= 1'b0;
            param_wr_addr   <= '0;
            param_wr_data   <= '0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            rec_q    <= rec_d;
            wb_sel_q <= wb_sel_d;
            mean_q   <= mean_d;
            var_q    <= var_d;

            if ((state_q == ST_IDLE) && cmd_valid) begin
                num_ch_q        <= cmd_channels;
                dp_training     <= cmd_training;
                dp_feature_size <= cmd_feature_size;
            end

            // Outputs are registered from the next state so they align with it.
            cmd_ready   <= (state_d == ST_IDLE);
            busy        <= (state_d != ST_IDLE);
            dp_start    <= (state_d == ST_LAUNCH);
            done        <= (state_d == ST_FIN);
            error       <= (state_d == ST_FIN) && err_d;
            param_wr_en <= (state_d == ST_WB);
            if (state_d == ST_WB) begin
                param_wr_addr <= rec_d + ADDR_W'(wb_sel_d ? OFF_VAR : OFF_MEAN);
                param_wr_data <= wb_sel_d ? var_d : mean_d;
            end

            if (fetch_last && !abort_hit)
                ch_index <= chan_q;
        end
    end

    bn_param_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch (
        .clk      (clk),
        .rst_n    (rst_n),
        .enter    (fetch_enter),
        .active   (fetch_active),
        .kill     (abort_hit),
        .rec_base (rec_d),
        .rd_data  (param_rd_data),
        .rd_en    (param_rd_en),
        .rd_addr  (param_rd_addr),
        .last     (fetch_last),
        .ch_gamma (ch_gamma),
        .ch_beta  (ch_beta),
        .ch_mean  (ch_mean),
        .ch_var   (ch_var)
    );

endmodule

// File: tb/tb_bn_layer_sequencer.sv
// Bench for bn_layer_sequencer: memory and datapath models plus a
// per-layer reference of reads, launches, writebacks and timing.
module tb_bn_layer_sequencer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int MAXC   = 8;

    logic              clk, rst_n;
    logic              cmd_valid, cmd_ready, cmd_training;
    logic [15:0]       cmd_channels, cmd_feature_size;
    logic [ADDR_W-1:0] cmd_param_base;
    logic              param_rd_en, param_wr_en;
    logic [ADDR_W-1:0] param_rd_addr, param_wr_addr;
    logic [DATA_W-1:0] param_rd_data, param_wr_data;
    logic [DATA_W-1:0] ch_gamma, ch_beta, ch_mean, ch_var;
    logic [15:0]       ch_index, dp_feature_size;
    logic              dp_start, dp_training, dp_done;
    logic [DATA_W-1:0] dp_new_mean, dp_new_var;
    logic              abort, busy, done, error;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int                dly [MAXC];
    logic [DATA_W-1:0] nmean [MAXC];
    logic [DATA_W-1:0] nvar [MAXC];

    bn_layer_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_channels(cmd_channels), .cmd_feature_size(cmd_feature_size),
        .cmd_training(cmd_training), .cmd_param_base(cmd_param_base),
        .param_rd_en(param_rd_en), .param_rd_addr(param_rd_addr), .param_rd_data(param_rd_data),
        .param_wr_en(param_wr_en), .param_wr_addr(param_wr_addr), .param_wr_data(param_wr_data),
        .ch_gamma(ch_gamma), .ch_beta(ch_beta), .ch_mean(ch_mean), .ch_var(ch_var),
        .ch_index(ch_index), .dp_start(dp_start), .dp_training(dp_training),
        .dp_feature_size(dp_feature_size), .dp_done(dp_done),
        .dp_new_mean(dp_new_mean), .dp_new_var(dp_new_var),
        .abort(abort), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parameter memory: one-cycle read latency.
    always @(posedge clk) if (param_rd_en) param_rd_data <= mem[param_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_layer(input int n, input int feat, input bit train,
                             input logic [ADDR_W-1:0] base, input int abort_cyc,
                             input bit abort_on_done, input bit spurious);
        logic [ADDR_W-1:0] rd_q[$];
        logic [ADDR_W-1:0] wa_q[$];
        logic [DATA_W-1:0] wd_q[$];
        int                wc_q[$];
        logic [DATA_W-1:0] sg_q[$], sb_q[$], sm_q[$], sv_q[$];
        int                si_q[$];
        int busy_cnt, done_cyc, abort_seen, cnt, ch_dp, exp_busy, exp_reads;
        bit pend, overlap, real_done, err_v;
        logic [ADDR_W-1:0] a, rec;
        busy_cnt = 0; done_cyc = -1; abort_seen = -1; cnt = 0; ch_dp = 0;
        pend = 0; overlap = 0; err_v = 0;

        @(negedge clk);
        cmd_valid        = 1'b1;
        cmd_channels     = 16'(n);
        cmd_feature_size = 16'(feat);
        cmd_training     = train;
        cmd_param_base   = base;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            dp_done   = 1'b0;
            real_done = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    dp_done     = 1'b1;
                    real_done   = 1'b1;
                    pend        = 1'b0;
                    dp_new_mean = nmean[(ch_dp - 1) % MAXC];
                    dp_new_var  = nvar[(ch_dp - 1) % MAXC];
                end
            end else if (spurious && ($urandom_range(0, 3) == 0)) begin
                dp_done     = 1'b1;
                dp_new_mean = 16'($urandom);
                dp_new_var  = 16'($urandom);
            end
            abort = (cyc == abort_cyc) || (abort_on_done && real_done);
            if (abort) abort_seen = cyc;

            if (param_rd_en) rd_q.push_back(param_rd_addr);
            if (param_wr_en) begin
                wa_q.push_back(param_wr_addr);
                wd_q.push_back(param_wr_data);
                wc_q.push_back(cyc);
            end
            if (param_rd_en && param_wr_en) overlap = 1'b1;
            if (dp_start) begin
                sg_q.push_back(ch_gamma); sb_q.push_back(ch_beta);
                sm_q.push_back(ch_mean);  sv_q.push_back(ch_var);
                si_q.push_back(int'(ch_index));
                chk("dp_training", dp_training, train);
                chk("dp_feature_size", dp_feature_size, feat);
                pend = 1'b1;
                cnt  = dly[ch_dp % MAXC];
                ch_dp++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                err_v    = error;
                break;
            end
            @(negedge clk);
        end
        dp_done = 1'b0;
        abort   = 1'b0;

        chk("done_seen", done_cyc > 0, 1);
        chk("rd_wr_overlap", overlap, 0);

        if (n == 0 || feat == 0) begin
            chk("empty_error", err_v, 1);
            chk("empty_done_cycle", done_cyc, 1);
            chk("empty_reads", rd_q.size(), 0);
            chk("empty_starts", sg_q.size(), 0);
        end else if (abort_cyc > 0 || abort_on_done) begin
            chk("abort_error", err_v, 1);
            chk("abort_done_cycle", done_cyc, abort_seen + 1);
            chk("abort_writes", wa_q.size(), 0);
            chk("abort_starts", sg_q.size(), abort_on_done ? 1 : 0);
            if (!abort_on_done) begin
                exp_reads = (abort_cyc < 4) ? abort_cyc : 4;
                chk("abort_reads", rd_q.size(), exp_reads);
            end
        end else begin
            exp_busy = 1;
            for (int c = 0; c < n; c++) exp_busy += 6 + dly[c] + (train ? 2 : 0);
            chk("busy_cycles", busy_cnt, exp_busy);
            chk("done_cycle", done_cyc, exp_busy);
            chk("layer_error", err_v, 0);
            chk("read_count", rd_q.size(), 4 * n);
            for (int i = 0; i < rd_q.size() && i < 4 * n; i++) begin
                a = base + ADDR_W'(i);
                chk("read_addr", rd_q[i], a);
            end
            chk("start_count", sg_q.size(), n);
            for (int c = 0; c < sg_q.size() && c < n; c++) begin
                rec = base + ADDR_W'(4 * c);
                a = rec;                 chk("ch_gamma", sg_q[c], mem[a]);
                a = rec + ADDR_W'(1);    chk("ch_beta",  sb_q[c], mem[a]);
                a = rec + ADDR_W'(2);    chk("ch_mean",  sm_q[c], mem[a]);
                a = rec + ADDR_W'(3);    chk("ch_var",   sv_q[c], mem[a]);
                chk("ch_index", si_q[c], c);
            end
            chk("write_count", wa_q.size(), train ? 2 * n : 0);
            if (train) begin
                for (int c = 0; c < n && 2 * c + 1 < wa_q.size(); c++) begin
                    rec = base + ADDR_W'(4 * c);
                    a = rec + ADDR_W'(2);  chk("wb_mean_addr", wa_q[2*c], a);
                    chk("wb_mean_data", wd_q[2*c], nmean[c]);
                    a = rec + ADDR_W'(3);  chk("wb_var_addr", wa_q[2*c+1], a);
                    chk("wb_var_data", wd_q[2*c+1], nvar[c]);
                    chk("wb_consecutive", wc_q[2*c+1], wc_q[2*c] + 1);
                end
            end
        end

        @(negedge clk);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
    endtask

    initial begin
        bit seen_wr, prev_start;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_channels = '0; cmd_feature_size = '0;
        cmd_training = 1'b0; cmd_param_base = '0; dp_done = 1'b0;
        dp_new_mean = '0; dp_new_var = '0; abort = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
        for (int c = 0; c < MAXC; c++) begin
            dly[c] = 3; nmean[c] = 16'($urandom); nvar[c] = 16'($urandom);
        end

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", param_rd_en, 0);
        chk("rst_wr_en", param_wr_en, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_ch_gamma", ch_gamma, 0);
        chk("rst_ch_index", ch_index, 0);
        chk("rst_rd_addr", param_rd_addr, 0);
        chk("rst_dp_feature", dp_feature_size, 0);
        rst_n = 1'b1;

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("idle_abort_ready", cmd_ready, 1);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        for (int i = 0; i < 8; i++) mem[12'h010 + i] = 16'(i + 1);
        run_layer(2, 4, 1'b0, 12'h010, -1, 1'b0, 1'b0);
        chk("gamma_ch0_literal", mem[12'h010], 16'd1);

        nmean[0] = 16'h0100; nvar[0] = 16'h0040;
        run_layer(1, 16, 1'b1, 12'h020, -1, 1'b0, 1'b0);

        run_layer(0, 4, 1'b0, 12'h040, -1, 1'b0, 1'b0);
        run_layer(3, 0, 1'b1, 12'h040, -1, 1'b0, 1'b0);

        run_layer(2, 8, 1'b0, 12'hFFC, -1, 1'b0, 1'b0);

        dly[0] = 2; dly[1] = 2;
        run_layer(2, 4, 1'b1, 12'h100, -1, 1'b1, 1'b0);
        run_layer(3, 4, 1'b1, 12'h200, 3, 1'b0, 1'b0);
        run_layer(3, 4, 1'b0, 12'h300, 5, 1'b0, 1'b0);

        repeat (6) begin
            for (int c = 0; c < MAXC; c++) begin
                dly[c] = $urandom_range(1, 4);
                nmean[c] = 16'($urandom); nvar[c] = 16'($urandom);
            end
            run_layer($urandom_range(1, MAXC), $urandom_range(1, 65535), 1'($urandom),
                      ADDR_W'($urandom), -1, 1'b0, 1'b1);
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_channels = 16'd1; cmd_feature_size = 16'd4;
        cmd_training = 1'b1; cmd_param_base = 12'h030;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen_wr = 1'b0; prev_start = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen_wr; cyc++) begin
            dp_done = prev_start;
            prev_start = dp_start;
            if (param_wr_en) seen_wr = 1'b1;
            else @(negedge clk);
        end
        chk("wb_reached", seen_wr, 1);
        dp_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wb_wr_en", param_wr_en, 0);
        chk("rst_wb_busy", busy, 0);
        chk("rst_wb_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        for (int c = 0; c < MAXC; c++) dly[c] = 2;
        run_layer(2, 4, 1'b1, 12'h050, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
